// File: rtl/sipo_frame_ctrl.sv
// Frame controller for an external SIPO shift register: synchronizes a serial
// port (sclk/sdi/cs_n), drives the shift register and hands out captured words.
module sipo_frame_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             sdi,
  input  logic             cs_n,
  input  logic [WIDTH-1:0] sr_q,
  output logic             sr_shift_en,
  output logic             sr_serial,
  output logic             sr_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE} state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic sdi_s1, sdi_s2;
  logic cs_s1, cs_s2, cs_s3;

  logic sclk_rise, cs_fall, cs_rise, take;

  // sdi uses the same two-flop depth as sclk so the sampled bit lines up with its edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      sdi_s1  <= 1'b0;
      sdi_s2  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      sdi_s1  <= sdi;
      sdi_s2  <= sdi_s1;
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign cs_fall   = ~cs_s2 & cs_s3;
  assign cs_rise   = cs_s2 & ~cs_s3;
  assign take      = data_valid & data_ready;
  assign busy      = (state != IDLE);

  // The final shift pulse is seen with bit_cnt already wrapped to 0; CAPTURE follows
  // it so the shift register has absorbed the last bit before sr_q is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      sr_shift_en <= 1'b0;
      sr_serial   <= 1'b0;
      sr_clr      <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      overrun     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      sr_shift_en <= 1'b0;
      sr_clr      <= 1'b0;
      frame_err   <= 1'b0;
      if (take)
        data_valid <= 1'b0;
      if (ovr_clr)
        overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= SHIFT;
            sr_clr  <= 1'b1;
            bit_cnt <= '0;
          end
        end

        SHIFT: begin
          if (sr_shift_en && bit_cnt == '0) begin
            state <= CAPTURE;
          end else if (cs_rise) begin
            state     <= IDLE;
            frame_err <= (bit_cnt != '0);
            bit_cnt   <= '0;
          end else if (sclk_rise) begin
            sr_shift_en <= 1'b1;
            sr_serial   <= sdi_s2;
            bit_cnt     <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
          end
        end

        CAPTURE: begin
          // A reload here overrides the handshake clear above
          if (!data_valid || data_ready) begin
            data_out   <= sr_q;
            data_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          if (cs_s2) begin
            state <= IDLE;
          end else begin
            state <= SHIFT;
            if (sclk_rise) begin
              sr_shift_en <= 1'b1;
              sr_serial   <= sdi_s2;
              bit_cnt     <= CW'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
